// File: rtl/riscv_pkg.sv
// Shared constants and types for the RISC-V front end.
package riscv_pkg;

    localparam logic [31:0] RV_NOP           = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

    typedef enum logic [1:0] {
        StReq,
        StWait,
        StHold
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush; head is presented combinationally on rdata.
module fetch_queue #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW + 1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_comb begin
        rdata = mem[rd_ptr];
        empty = (count == '0);
    end

endmodule

// File: rtl/riscv_fetch_unit.sv
// IF stage: owns the PC, drives the imem req/gnt/rvalid handshake and feeds IF/ID from a queue.
module riscv_fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned         XLEN     = 32,
    parameter logic [XLEN-1:0]     RESET_PC = XLEN'(RESET_PC_DEFAULT),
    parameter int unsigned         QDEPTH   = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [31:0]     i_imem_rdata,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_stall,
    output logic            o_if_valid,
    output logic [31:0]     o_if_instr,
    output logic [XLEN-1:0] o_if_pc,
    output logic [XLEN-1:0] o_if_pc4
);

    localparam int unsigned CW = $clog2(QDEPTH) + 1;

    fetch_state_e     state;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  req_pc;
    logic             discard;

    logic [XLEN+31:0] q_wdata;
    logic [XLEN+31:0] q_rdata;
    logic [CW-1:0]    q_count;
    logic             q_empty;
    logic             push;
    logic             pop;
    logic             resp;
    logic             granted;
    logic [CW-1:0]    count_after;
    logic             space_after;

    fetch_queue #(
        .WIDTH (XLEN + 32),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk   (i_clk),
        .rst   (i_rst),
        .flush (i_redirect),
        .push  (push),
        .wdata (q_wdata),
        .pop   (pop),
        .rdata (q_rdata),
        .count (q_count),
        .empty (q_empty)
    );

    always_comb begin
        o_if_valid  = !q_empty;
        pop         = o_if_valid && !i_stall;
        resp        = (state == StWait) && i_imem_rvalid;
        push        = resp && !discard && !i_redirect;
        // Occupancy once this cycle's pop and push have landed.
        count_after = q_count - CW'(pop) + CW'(push);
        space_after = count_after < CW'(QDEPTH);
        o_imem_req  = (state == StReq) || (resp && space_after && !i_redirect);
        o_imem_addr = pc;
        granted     = o_imem_req && i_imem_gnt;
        q_wdata     = {req_pc, i_imem_rdata};
        o_if_instr  = o_if_valid ? q_rdata[31:0] : RV_NOP;
        o_if_pc     = q_rdata[XLEN+31:32];
        o_if_pc4    = o_if_pc + XLEN'(4);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= StReq;
            pc      <= RESET_PC;
            req_pc  <= RESET_PC;
            discard <= 1'b0;
        end else if (i_redirect) begin
            pc <= {i_redirect_pc[XLEN-1:2], 2'b00};
            // A request still in flight must have its response thrown away.
            if ((state == StWait && !i_imem_rvalid) || granted) begin
                discard <= 1'b1;
                state   <= StWait;
            end else begin
                discard <= 1'b0;
                state   <= StReq;
            end
        end else begin
            if (granted) begin
                req_pc <= pc;
                pc     <= pc + XLEN'(4);
            end
            unique case (state)
                StReq: begin
                    if (granted) begin
                        state <= StWait;
                    end
                end
                StWait: begin
                    if (i_imem_rvalid) begin
                        discard <= 1'b0;
                        if (granted) begin
                            state <= StWait;
                        end else if (space_after) begin
                            state <= StReq;
                        end else begin
                            state <= StHold;
                        end
                    end
                end
                StHold: begin
                    if (pop) begin
                        state <= StReq;
                    end
                end
                default: state <= StReq;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed bench for riscv_fetch_unit: streaming table plus redirect, flush, wrap and reset cases.
module tb_riscv_fetch_unit;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] RPC  = 32'h0040_0000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;

    logic        auto;
    int          tests;
    int          fails;

    typedef struct {
        logic        stall;
        logic        valid;
        logic [31:0] pc;
        logic        req;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs [14];

    riscv_fetch_unit dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_gnt    (imem_gnt),
        .i_imem_rvalid (imem_rvalid),
        .i_imem_rdata  (imem_rdata),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .i_stall       (stall),
        .o_if_valid    (if_valid),
        .o_if_instr    (if_instr),
        .o_if_pc       (if_pc),
        .o_if_pc4      (if_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Memory model returns ~addr as the instruction, so the expected instr is ~pc.
    task automatic check_out(input string tag, input logic ev, input logic [31:0] epc,
                             input logic er, input logic [31:0] ea);
        chk($sformatf("%s valid", tag), 32'(if_valid), 32'(ev));
        if (ev) begin
            chk($sformatf("%s pc", tag), if_pc, epc);
            chk($sformatf("%s instr", tag), if_instr, ~epc);
            chk($sformatf("%s pc4", tag), if_pc4, epc + 32'd4);
        end else begin
            chk($sformatf("%s nop", tag), if_instr, NOP);
        end
        chk($sformatf("%s req", tag), 32'(imem_req), 32'(er));
        if (er) begin
            chk($sformatf("%s addr", tag), imem_addr, ea);
        end
    endtask

    // Advance one clock; auto memory answers one cycle after each grant.
    task automatic step();
        logic        take;
        logic [31:0] ta;
        take = auto && imem_req && imem_gnt;
        ta   = imem_addr;
        @(posedge clk);
        #1;
        if (auto) begin
            imem_rvalid = take;
            imem_rdata  = ~ta;
        end
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        auto        = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
        stall       = 1'b0;
        repeat (3) step();
        rst = 1'b0;
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        rst         = 1'b1;
        auto        = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        stall       = 1'b0;

        vecs[0]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h0040_0000};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h0040_0004};
        vecs[2]  = '{1'b0, 1'b1, 32'h0040_0000, 1'b1, 32'h0040_0008};
        vecs[3]  = '{1'b0, 1'b1, 32'h0040_0004, 1'b1, 32'h0040_000C};
        vecs[4]  = '{1'b1, 1'b1, 32'h0040_0008, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b1, 32'h0040_0008, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b1, 32'h0040_0008, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 1'b1, 32'h0040_0008, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 1'b1, 32'h0040_0008, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 32'h0040_0008, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 1'b1, 32'h0040_000C, 1'b1, 32'h0040_0010};
        vecs[11] = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h0040_0014};
        vecs[12] = '{1'b0, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0018};
        vecs[13] = '{1'b0, 1'b1, 32'h0040_0014, 1'b1, 32'h0040_001C};

        #1;
        // Reset state and streaming with a stall window.
        do_reset();
        #1;
        check_out("reset", 1'b0, 32'h0, 1'b1, RPC);
        imem_gnt = 1'b1;
        auto     = 1'b1;
        for (int i = 0; i < 14; i++) begin
            stall = vecs[i].stall;
            #1;
            check_out($sformatf("stream[%0d]", i), vecs[i].valid, vecs[i].pc,
                      vecs[i].req, vecs[i].addr);
            step();
        end

        // Redirect while a request is outstanding.
        do_reset();
        imem_gnt = 1'b1;
        #1;
        check_out("rdw c0", 1'b0, 32'h0, 1'b1, RPC);
        step();
        imem_gnt    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0040_0103;
        #1;
        chk("rdw c1 req", 32'(imem_req), 32'd0);
        step();
        redirect    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        imem_gnt    = 1'b1;
        #1;
        check_out("rdw c2", 1'b0, 32'h0, 1'b1, 32'h0040_0100);
        step();
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b0;
        #1;
        check_out("rdw c3", 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        imem_rvalid = 1'b1;
        imem_rdata  = ~32'h0040_0100;
        #1;
        check_out("rdw c4", 1'b0, 32'h0, 1'b1, 32'h0040_0104);
        step();
        imem_rvalid = 1'b0;
        #1;
        check_out("rdw c5", 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0104);
        step();

        // Redirect colliding with rvalid, then with a full queue.
        do_reset();
        stall    = 1'b1;
        imem_gnt = 1'b1;
        auto     = 1'b1;
        #1;
        check_out("flush a", 1'b0, 32'h0, 1'b1, RPC);
        step();
        #1;
        check_out("flush b", 1'b0, 32'h0, 1'b1, 32'h0040_0004);
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0040_0200;
        #1;
        check_out("flush c", 1'b1, RPC, 1'b0, 32'h0);
        step();
        redirect = 1'b0;
        #1;
        check_out("flush d", 1'b0, 32'h0, 1'b1, 32'h0040_0200);
        step();
        #1;
        check_out("flush e", 1'b0, 32'h0, 1'b1, 32'h0040_0204);
        step();
        #1;
        check_out("flush f", 1'b1, 32'h0040_0200, 1'b0, 32'h0);
        step();
        auto        = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0BAD;
        redirect    = 1'b1;
        redirect_pc = 32'h0040_0300;
        #1;
        check_out("flush g", 1'b1, 32'h0040_0200, 1'b0, 32'h0);
        step();
        redirect    = 1'b0;
        imem_rvalid = 1'b0;
        stall       = 1'b0;
        auto        = 1'b1;
        #1;
        check_out("flush h", 1'b0, 32'h0, 1'b1, 32'h0040_0300);
        step();
        #1;
        check_out("flush i", 1'b0, 32'h0, 1'b1, 32'h0040_0304);
        step();
        #1;
        check_out("flush j", 1'b1, 32'h0040_0300, 1'b1, 32'h0040_0308);
        step();

        // PC wrap, then reset in the middle of a transaction.
        do_reset();
        imem_gnt    = 1'b1;
        auto        = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        #1;
        check_out("wrap a", 1'b0, 32'h0, 1'b1, RPC);
        step();
        redirect = 1'b0;
        #1;
        check_out("wrap b", 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        step();
        #1;
        check_out("wrap c", 1'b0, 32'h0, 1'b1, 32'h0000_0000);
        step();
        #1;
        check_out("wrap d", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0000_0004);
        step();
        rst  = 1'b1;
        auto = 1'b0;
        #1;
        step();
        rst         = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        imem_gnt    = 1'b0;
        #1;
        check_out("midrst f", 1'b0, 32'h0, 1'b1, RPC);
        step();
        imem_rvalid = 1'b0;
        #1;
        check_out("midrst g", 1'b0, 32'h0, 1'b1, RPC);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
